// File: rtl/guarded_fsm.sv
// guarded_fsm: commits user-requested states only on hold/advance/abort, locks out after repeated
// rejects, and recovers a corrupted state register to 0. Define GUARDED_FSM_PARITY_EN for a parity bit.
module guarded_fsm #(
  parameter int STATE_W     = 3,
  parameter int NUM_STATES  = 5,
  parameter int MAX_REJECT  = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [STATE_W-1:0] req_state,
  output logic               ack,
  output logic               nack,
  output logic [STATE_W-1:0] state_o,
  output logic               locked,
  output logic               fault,
  input  logic               clr_fault
);

  localparam int REJ_W  = $clog2(MAX_REJECT + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [STATE_W:0]    NUM_EXT   = (STATE_W + 1)'(NUM_STATES);
  localparam logic [STATE_W-1:0]  SAFE      = {STATE_W{1'b0}};
  localparam logic [REJ_W-1:0]    REJ_ZERO  = {REJ_W{1'b0}};
  localparam logic [REJ_W-1:0]    REJ_LAST  = REJ_W'(MAX_REJECT - 1);
  localparam logic [REJ_W-1:0]    REJ_MAX   = REJ_W'(MAX_REJECT);
  localparam logic [LOCK_W-1:0]   LOCK_ZERO = {LOCK_W{1'b0}};
  localparam logic [LOCK_W-1:0]   LOCK_ONE  = LOCK_W'(1'b1);
  localparam logic [LOCK_W-1:0]   LOCK_LOAD = LOCK_W'(LOCK_CYCLES);

  typedef enum logic [0:0] {
    CTRL_ACTIVE = 1'b0,
    CTRL_LOCKED = 1'b1
  } ctrl_e;

  ctrl_e               r_ctrl;
  ctrl_e               w_ctrl_nxt;
  logic [STATE_W-1:0]  r_state;
  logic [STATE_W-1:0]  w_state_nxt;
  logic [REJ_W-1:0]    r_rej;
  logic [REJ_W-1:0]    w_rej_nxt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [LOCK_W-1:0]   w_lock_nxt;
  logic                r_ack;
  logic                w_ack_nxt;
  logic                r_nack;
  logic                w_nack_nxt;
  logic                r_fault;
  logic                w_fault_nxt;
  logic                w_accept;
  logic                w_legal;
  logic                w_range_bad;
  logic                w_integrity_bad;
  logic [STATE_W:0]    w_state_ext;
  logic [STATE_W:0]    w_req_ext;

  assign w_state_ext = {1'b0, r_state};
  assign w_req_ext   = {1'b0, req_state};
  assign w_range_bad = (w_state_ext >= NUM_EXT);

`ifdef GUARDED_FSM_PARITY_EN
  function automatic logic even_parity(input logic [STATE_W-1:0] v);
    return ^v;
  endfunction

  logic r_parity;

  // Parity bit tracks whatever value the state register takes next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= even_parity(w_state_nxt);
    end
  end

  assign w_integrity_bad = w_range_bad | (r_parity != even_parity(r_state));
`else
  assign w_integrity_bad = w_range_bad;
`endif

  assign w_accept    = req_valid & (r_ctrl == CTRL_ACTIVE);
  assign w_legal     = (req_state == r_state) | (req_state == SAFE) |
                       ((w_req_ext == (w_state_ext + {{STATE_W{1'b0}}, 1'b1})) & (w_req_ext < NUM_EXT));
  // New detections win over a same-cycle clear.
  assign w_fault_nxt = w_integrity_bad | (r_fault & ~clr_fault);

  // Next-state decision: integrity recovery, then lock countdown, then request checking.
  always_comb begin
    w_ctrl_nxt  = r_ctrl;
    w_state_nxt = r_state;
    w_rej_nxt   = r_rej;
    w_lock_nxt  = r_lock_cnt;
    w_ack_nxt   = 1'b0;
    w_nack_nxt  = 1'b0;
    if (w_integrity_bad) begin
      w_state_nxt = SAFE;
      w_nack_nxt  = w_accept;
    end else begin
      case (r_ctrl)
        CTRL_ACTIVE: begin
          if (w_accept && w_legal) begin
            w_state_nxt = req_state;
            w_ack_nxt   = 1'b1;
            w_rej_nxt   = REJ_ZERO;
          end else if (w_accept) begin
            w_nack_nxt = 1'b1;
            if (r_rej >= REJ_LAST) begin
              w_ctrl_nxt = CTRL_LOCKED;
              w_rej_nxt  = REJ_MAX;
              w_lock_nxt = LOCK_LOAD;
            end else begin
              w_rej_nxt = r_rej + 1'b1;
            end
          end else begin
            w_rej_nxt = r_rej;
          end
        end
        CTRL_LOCKED: begin
          if (r_lock_cnt <= LOCK_ONE) begin
            w_ctrl_nxt  = CTRL_ACTIVE;
            w_state_nxt = SAFE;
            w_rej_nxt   = REJ_ZERO;
            w_lock_nxt  = LOCK_ZERO;
          end else begin
            w_lock_nxt = r_lock_cnt - LOCK_ONE;
          end
        end
        default: begin
          w_ctrl_nxt  = CTRL_ACTIVE;
          w_state_nxt = SAFE;
          w_rej_nxt   = REJ_ZERO;
          w_lock_nxt  = LOCK_ZERO;
        end
      endcase
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl     <= CTRL_ACTIVE;
      r_state    <= SAFE;
      r_rej      <= REJ_ZERO;
      r_lock_cnt <= LOCK_ZERO;
      r_ack      <= 1'b0;
      r_nack     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_state    <= w_state_nxt;
      r_rej      <= w_rej_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_ack      <= w_ack_nxt;
      r_nack     <= w_nack_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  assign state_o   = r_state;
  assign ack       = r_ack;
  assign nack      = r_nack;
  assign fault     = r_fault;
  assign locked    = (r_ctrl == CTRL_LOCKED);
  assign req_ready = ~locked;

endmodule

// File: doc/guarded_fsm.md
# guarded_fsm

Parametrised user-driven state machine. Each requested next state is checked against a fixed transition rule before it is committed. Illegal requests are rejected. Repeated rejections trigger a timed lockout. A corrupted state register is forced back to the safe state and flagged. The block sits between the user command interface and the downstream mode-decode logic, and is the hardened successor to the direct "state follows user input" controller.

## Interface
- STATE_W, 3: width of state encodings; must satisfy 2^STATE_W >= NUM_STATES
- NUM_STATES, 5: legal encodings are 0..NUM_STATES-1; 0 is the safe state
- MAX_REJECT, 4: consecutive rejections that trigger lockout (>=1)
- LOCK_CYCLES, 16: lockout duration in clk cycles (>=1)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; combinational, equals !locked
- req_state  in  STATE_W  requested next state
- ack  out  1  one-cycle pulse: previous-cycle request committed
- nack  out  1  one-cycle pulse: previous-cycle request rejected
- state_o  out  STATE_W  current committed state (registered)
- locked  out  1  lockout active
- fault  out  1  sticky: illegal state encoding was detected
- clr_fault  in  1  clears fault

## Operation
- Handshake: a request is accepted on a cycle where req_valid && req_ready. Back-to-back requests are allowed, one per cycle.
- A request from current state s is legal only if req_state is one of:
  - s (hold)
  - s+1, when s+1 < NUM_STATES (advance)
  - 0 (abort)
- Any other value, including req_state >= NUM_STATES, is illegal.
- Legal request: state_o <= req_state, ack pulses, reject count clears to 0.
- Illegal request: state_o is unchanged, nack pulses, reject count increments.
- Control FSM states:
  - ACTIVE: requests are processed.
  - LOCKED: req_ready=0, requests are ignored, and the lock counter counts down.
- ACTIVE -> LOCKED on the nack that brings the reject count to MAX_REJECT.
- LOCKED -> ACTIVE when the lock counter expires. On that exit, state_o is forced to 0 and the reject count is cleared.
- Integrity check: every cycle, if state_o >= NUM_STATES, then on the next edge:
  - state_o <= 0 and fault <= 1
  - any request accepted in that cycle gets nack, but does not count toward the reject count
  - integrity recovery takes priority over request processing and over lock exit
- fault is sticky. clr_fault clears it on the next edge. If a new detection occurs in the same cycle as clr_fault, fault stays 1.
- Reject and lock counters saturate and never wrap.

## Timing
- Reset values: state_o=0, ack=0, nack=0, locked=0, fault=0, reject count=0, control FSM=ACTIVE. req_ready=1 in the first cycle after reset.
- Decision latency: 1 cycle. Request accepted at edge N -> state_o, ack/nack, locked updated after edge N+1.
- At most one of ack/nack is high in any cycle.
- locked rises on the same edge as the MAX_REJECT-th nack. It stays high for exactly LOCK_CYCLES cycles, then falls together with state_o returning to 0.
- Reset asserted mid-lockout or mid-recovery returns all state to reset values at the next edge.

## Configuration
- GUARDED_FSM_PARITY_EN defined:
  - state register carries an extra even-parity bit, written on every update.
  - a parity mismatch is treated exactly like an out-of-range encoding: recovery to 0, fault set.
- Not defined: no parity bit; only the out-of-range check is performed.

## Test plan
- Reset, then requests 1,2,3,4 in consecutive cycles -> four ack pulses; state_o steps 1,2,3,4; no nack.
- At state 2, request 4 -> nack one cycle later; state_o stays 2. Then request 0 -> ack; state_o=0; reject count cleared.
- Four consecutive illegal requests (e.g. 3 from state 0) -> locked=1 with the 4th nack; req_ready=0 for 16 cycles; then locked=0 and state_o=0. A request issued during lockout produces no ack and no nack.
- Force state register to 6 -> next edge state_o=0, fault=1. Pulse clr_fault -> fault=0. Force again in the same cycle as clr_fault -> fault stays 1.
- Drive rst_n=0 at cycle 5 of a lockout -> next edge locked=0, state_o=0, req_ready=1.
- With GUARDED_FSM_PARITY_EN: flip only the parity bit at state 3 -> state_o=0, fault=1. Without the macro, the same test is skipped.
